// File: rtl/frame_stream_source_if.sv
// ============================================================================
//  Module      : frame_stream_source_if
//  Description : Frame-buffer read port plus pixel stream handshake for
//                frame_stream_source. master = the source block,
//                slave = frame buffer / downstream sink side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface frame_stream_source_if;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [11:0] rd_data;
    logic        ready_in;
    logic        valid_out;
    logic        startofpacket_out;
    logic        endofpacket_out;
    logic [11:0] data_out;

    modport master (
        output rd_en, rd_addr, valid_out, startofpacket_out, endofpacket_out, data_out,
        input  rd_data, ready_in
    );

    modport slave (
        input  rd_en, rd_addr, valid_out, startofpacket_out, endofpacket_out, data_out,
        output rd_data, ready_in
    );
endinterface

`default_nettype wire

// File: rtl/frame_stream_source.sv
// ============================================================================
//  Module      : frame_stream_source
//  Description : Reads one RGB444 frame from a frame buffer (1-cycle read
//                latency) in raster order and emits it as a valid/ready
//                pixel stream with sop/eop markers. A 3-entry skid FIFO plus
//                credit-based read issue keeps ready_in off the read path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_stream_source #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter bit CONTINUOUS   = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    frame_stream_source_if.master  bus,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [16:0] LAST_ADDR = 17'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [16:0] addr, addr_next;
    logic        issue;
    logic        credit_ok;

    // Read issued last cycle: its data is on rd_data now, with its tags.
    logic        inflight, inflight_sop, inflight_eop;

    logic [11:0] fifo_data [3];
    logic        fifo_sop  [3];
    logic        fifo_eop  [3];
    logic [1:0]  wr_ptr, rd_ptr, count;
    logic        push, pop, not_empty, eop_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credits: FIFO slots not yet claimed by stored or in-flight pixels.
    // Depends only on registers, so ready_in never reaches rd_en.
    assign credit_ok = ({1'b0, count} + {2'b00, inflight}) < 3'd3;
    assign not_empty = (count != 2'd0);
    assign push      = inflight;
    assign pop       = not_empty && bus.ready_in;
    assign eop_pop   = pop && fifo_eop[rd_ptr];

    // Next-state, read issue and address sequencing.
    // In continuous mode the address wraps to 0 as soon as the last read is
    // issued and DRAIN keeps prefetching the next frame, so the next sop
    // follows eop with no bubble.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    addr_next  = '0;
                end
            end
            RUN: begin
                issue = credit_ok;
                if (issue) begin
                    if (addr == LAST_ADDR) begin
                        state_next = DRAIN;
                        addr_next  = CONTINUOUS ? 17'd0 : addr;
                    end else begin
                        addr_next = addr + 17'd1;
                    end
                end
            end
            DRAIN: begin
                issue = CONTINUOUS && credit_ok && (addr != LAST_ADDR);
                if (issue) begin
                    addr_next = addr + 17'd1;
                end
                if (eop_pop) begin
                    state_next = CONTINUOUS ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: state, address, in-flight tracking, FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_next;
            addr         <= addr_next;
            inflight     <= issue;
            inflight_sop <= issue && (addr == 17'd0);
            inflight_eop <= issue && (addr == LAST_ADDR);
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            frame_done <= eop_pop;
        end
    end

    // FIFO storage; contents are only observed through not_empty gating.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.rd_data;
            fifo_sop[wr_ptr]  <= inflight_sop;
            fifo_eop[wr_ptr]  <= inflight_eop;
        end
    end

    assign bus.rd_en             = issue;
    assign bus.rd_addr           = addr;
    assign bus.valid_out         = not_empty;
    assign bus.data_out          = not_empty ? fifo_data[rd_ptr] : 12'd0;
    assign bus.startofpacket_out = not_empty && fifo_sop[rd_ptr];
    assign bus.endofpacket_out   = not_empty && fifo_eop[rd_ptr];
    assign busy                  = (state != IDLE);

endmodule

`default_nettype wire

// File: doc/frame_stream_source.md
FRAME_STREAM_SOURCE -- requirements
Module: frame_stream_source

Interface
REQ-001 The block SHALL have parameter IMAGE_WIDTH, default 320, pixels per row.
REQ-002 The block SHALL have parameter IMAGE_HEIGHT, default 240, rows per frame.
REQ-003 The block SHALL have parameter CONTINUOUS, default 0; when 1, frames repeat back-to-back without a new start.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to emit one frame; sampled only in IDLE.
REQ-007 rd_en  output  1  frame-buffer read strobe.
REQ-008 rd_addr  output  17  pixel address, row*IMAGE_WIDTH+col, 0..W*H-1.
REQ-009 rd_data  input  12  RGB444 {R[11:8],G[7:4],B[3:0]}; valid exactly one cycle after rd_en.
REQ-010 ready_in  input  1  downstream ready, ready latency 0.
REQ-011 valid_out  output  1  data_out holds a valid pixel.
REQ-012 startofpacket_out  output  1  high on the first pixel of a frame.
REQ-013 endofpacket_out  output  1  high on the last pixel of a frame.
REQ-014 data_out  output  12  RGB444 pixel.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 frame_done  output  1  one-cycle pulse when the eop beat is accepted.

Function
REQ-017 A beat SHALL transfer exactly on a rising edge where valid_out && ready_in.
REQ-018 Once valid_out is high, valid_out, data_out, sop and eop SHALL stay stable until the beat transfers.
REQ-019 States SHALL be IDLE, RUN and DRAIN.
REQ-020 IDLE -> RUN on start=1, with the read address cleared to 0; start in RUN/DRAIN SHALL be ignored.
REQ-021 RUN SHALL assert rd_en when (FIFO occupancy + reads in flight) < 3, with no combinational path from ready_in to rd_en.
REQ-022 Each issued read SHALL increment rd_addr by 1; RUN -> DRAIN on the edge issuing address W*H-1.
REQ-023 rd_data SHALL be written into a 3-entry FIFO together with sop (address 0) and eop (address W*H-1) tags.
REQ-024 valid_out SHALL equal FIFO-not-empty; the head entry drives data_out, startofpacket_out and endofpacket_out.
REQ-025 The first valid_out SHALL assert in the second cycle after the edge that samples start.
REQ-026 With ready_in held high, throughput SHALL be one pixel per cycle for the entire frame.
REQ-027 DRAIN -> IDLE when the eop beat transfers, with frame_done pulsed on that edge; if CONTINUOUS=1, DRAIN -> RUN instead, with the address cleared and no idle beat inserted.
REQ-028 A push and a pop in the same cycle SHALL leave occupancy unchanged; the FIFO SHALL never overflow or underflow.
REQ-029 Pixels SHALL be emitted in address order with no drops or duplicates under any ready_in pattern.
REQ-030 rd_addr SHALL hold its last value while rd_en is low.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE and FIFO/in-flight counts 0.
REQ-032 While rst_n=0, rd_en, rd_addr, valid_out, startofpacket_out, endofpacket_out, data_out, busy and frame_done SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame and any in-flight read; the next start SHALL begin at address 0 with sop.

Verification
REQ-034 Scenario 1: W=320, H=240, mem[i]=i[11:0], ready_in=1, start pulse -> 76800 beats on consecutive cycles, sop with data 0x000, eop with data (76799 mod 4096), one frame_done.
REQ-035 Scenario 2: W=4, H=2, ready_in random 50% -> 8 beats in order 0..7, outputs stable during every stall, sop only on beat 0, eop only on beat 7.
REQ-036 Scenario 3: start re-pulsed during RUN and DRAIN -> ignored, exactly 8 beats, one frame_done.
REQ-037 Scenario 4: rst_n low after beat 3 of a W=4, H=2 frame -> all outputs 0; next start yields beats 0..7 with sop on beat 0.
REQ-038 Scenario 5: CONTINUOUS=1, W=4, H=2, ready_in=1 -> eop on beat 7, sop on beat 8 in the next cycle, and addresses wrap to 0.
REQ-039 Scenario 6: ready_in=0 for 20 cycles after start -> rd_en issues at most 3 reads, valid_out holds pixel 0 with sop, and no read is lost when ready_in returns.
